// File: rtl/io_exchange_port_if.sv
// io_exchange_port_if: host/core handshake and data signals of io_exchange_port
interface io_exchange_port_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] IOIn;
  logic              core_in_rd;
  logic              core_in_empty;
  logic [DATA_W-1:0] core_out_data;
  logic              core_out_wr;
  logic              core_out_full;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic              out_overrun;
  modport slave (
    input  host_in_data, host_in_valid, core_in_rd, core_out_data, core_out_wr, host_out_ready,
    output host_in_ready, IOIn, core_in_empty, core_out_full, host_out_data, host_out_valid, out_overrun
  );
  modport master (
    output host_in_data, host_in_valid, core_in_rd, core_out_data, core_out_wr, host_out_ready,
    input  host_in_ready, IOIn, core_in_empty, core_out_full, host_out_data, host_out_valid, out_overrun
  );
endinterface

// File: rtl/io_exchange_port.sv
// io_exchange_port: host operand FIFO feeding core IOIn, plus result capture register returned to host.
// Define IO_EXCHANGE_HOLD_LAST_EN to keep the last popped operand on IOIn while the FIFO is empty.
module io_exchange_port #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input logic CLK,
  input logic reset,
  io_exchange_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {OUT_IDLE, OUT_HOLD} state_t;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, empty_q, push, pop;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ovr_q, ovr_d;
  assign push  = bus.host_in_valid && !full_q;
  assign pop   = bus.core_in_rd && !empty_q;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= bus.host_in_data;
  // full/empty kept as registers so the status outputs have no input-to-output path
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= cnt_d == '0;
    end
`ifdef IO_EXCHANGE_HOLD_LAST_EN
  logic [DATA_W-1:0] last_q;
  always_ff @(posedge CLK or posedge reset)
    if (reset) last_q <= '0;
    else if (pop) last_q <= mem_q[rd_q];
  assign bus.IOIn = empty_q ? last_q : mem_q[rd_q];
`else
  assign bus.IOIn = empty_q ? '0 : mem_q[rd_q];
`endif
  assign bus.host_in_ready = !full_q;
  assign bus.core_in_empty = empty_q;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state_q <= OUT_IDLE;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  // a write while holding an unaccepted word is dropped and flagged
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    if (state_q == OUT_IDLE) begin
      state_d = bus.core_out_wr ? OUT_HOLD : OUT_IDLE;
      out_d   = bus.core_out_wr ? bus.core_out_data : out_q;
    end else if (bus.host_out_ready) begin
      state_d = bus.core_out_wr ? OUT_HOLD : OUT_IDLE;
      out_d   = bus.core_out_wr ? bus.core_out_data : out_q;
    end else begin
      ovr_d   = ovr_q | bus.core_out_wr;
    end
  end
  assign bus.host_out_valid = state_q == OUT_HOLD;
  assign bus.core_out_full  = state_q == OUT_HOLD;
  assign bus.host_out_data  = out_q;
  assign bus.out_overrun    = ovr_q;
endmodule
